// File: rtl/detect_count_display_if.sv
// Signal bundle between the detector/board logic and detect_count_display.
// z and clr are plain levels sampled every rising clk edge; there is no valid/ready handshake.
interface detect_count_display_if;
  logic        z;
  logic        clr;
  logic [15:0] count_bcd;
  logic        det_pulse;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [1:0]  scan_state;

  modport master (
    output z, clr,
    input  count_bcd, det_pulse, an, seg, dp, scan_state
  );

  modport slave (
    input  z, clr,
    output count_bcd, det_pulse, an, seg, dp, scan_state
  );
endinterface

// File: rtl/detect_count_display.sv
// Counts rising edges of the detector output in 4-digit BCD and scans the
// count onto a common-anode 7-segment display (active-low an/seg/dp).
module detect_count_display #(
  parameter int REFRESH_DIV = 100000,
  parameter int DIV_W       = 17
) (
  input  logic                   clk,
  input  logic                   reset,
  detect_count_display_if.slave  bus
);

  typedef enum logic [1:0] {D0 = 2'd0, D1 = 2'd1, D2 = 2'd2, D3 = 2'd3} scan_t;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

  logic             r_z_d;
  logic             r_det_pulse;
  logic [15:0]      r_count;
  logic [DIV_W-1:0] r_div;
  scan_t            r_state;
  logic [3:0]       r_an;
  logic [6:0]       r_seg;

  logic             w_rise;
  logic             w_div_tc;
  logic             w_carry;
  logic [15:0]      w_count_inc;
  logic [15:0]      w_count_nxt;
  scan_t            w_state_nxt;
  logic [3:0]       w_an_nxt;
  logic [3:0]       w_digit_nxt;
  logic [6:0]       w_seg_nxt;

  assign w_rise   = bus.z & ~r_z_d;
  assign w_div_tc = (r_div == DIV_LAST);

  // Ripple-carry BCD increment; a digit >= 9 rolls to 0 so a corrupt digit self-heals.
  always_comb begin
    w_count_inc = r_count;
    w_carry     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (w_carry) begin
        if (r_count[4*i +: 4] >= 4'd9) begin
          w_count_inc[4*i +: 4] = 4'd0;
        end else begin
          w_count_inc[4*i +: 4] = r_count[4*i +: 4] + 4'd1;
          w_carry               = 1'b0;
        end
      end
    end
  end

  assign w_count_nxt = bus.clr ? 16'h0000 : (w_rise ? w_count_inc : r_count);

  // Next scan state plus the anode/segment pattern for that state, so an and seg load together.
  always_comb begin
    w_state_nxt = r_state;
    w_an_nxt    = 4'b1111;
    w_digit_nxt = 4'hF;
    w_seg_nxt   = 7'b1111111;
    if (w_div_tc) begin
      case (r_state)
        D0:      w_state_nxt = D1;
        D1:      w_state_nxt = D2;
        D2:      w_state_nxt = D3;
        D3:      w_state_nxt = D0;
        default: w_state_nxt = D0;
      endcase
    end
    case (w_state_nxt)
      D0:      begin w_an_nxt = 4'b1110; w_digit_nxt = w_count_nxt[3:0];   end
      D1:      begin w_an_nxt = 4'b1101; w_digit_nxt = w_count_nxt[7:4];   end
      D2:      begin w_an_nxt = 4'b1011; w_digit_nxt = w_count_nxt[11:8];  end
      D3:      begin w_an_nxt = 4'b0111; w_digit_nxt = w_count_nxt[15:12]; end
      default: begin w_an_nxt = 4'b1111; w_digit_nxt = 4'hF;               end
    endcase
    case (w_digit_nxt)
      4'd0:    w_seg_nxt = 7'b1000000;
      4'd1:    w_seg_nxt = 7'b1111001;
      4'd2:    w_seg_nxt = 7'b0100100;
      4'd3:    w_seg_nxt = 7'b0110000;
      4'd4:    w_seg_nxt = 7'b0011001;
      4'd5:    w_seg_nxt = 7'b0010010;
      4'd6:    w_seg_nxt = 7'b0000010;
      4'd7:    w_seg_nxt = 7'b1111000;
      4'd8:    w_seg_nxt = 7'b0000000;
      4'd9:    w_seg_nxt = 7'b0010000;
      default: w_seg_nxt = 7'b1111111;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= D0;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_z_d       <= 1'b0;
      r_det_pulse <= 1'b0;
      r_count     <= 16'h0000;
      r_div       <= '0;
      r_an        <= 4'b1110;
      r_seg       <= 7'b1000000;
    end else begin
      r_z_d       <= bus.z;
      r_det_pulse <= w_rise;
      r_count     <= w_count_nxt;
      r_div       <= w_div_tc ? '0 : r_div + DIV_W'(1);
      r_an        <= w_an_nxt;
      r_seg       <= w_seg_nxt;
    end
  end

  assign bus.count_bcd  = r_count;
  assign bus.det_pulse  = r_det_pulse;
  assign bus.an         = r_an;
  assign bus.seg        = r_seg;
  assign bus.dp         = 1'b1;
  assign bus.scan_state = r_state;

endmodule

// File: tb/tb_detect_count_display.sv
// Directed bench for detect_count_display: vector table for edge/clear behaviour,
// hand sequences for carries, scan order and asynchronous reset.
module tb_detect_count_display;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;
  int   n_events;
  logic [15:0] exp_q[$];

  detect_count_display_if bus ();

  detect_count_display #(.REFRESH_DIV(4), .DIV_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        z;
    logic        clr;
    logic [15:0] exp_count;
    logic        exp_pulse;
  } vec_t;

  vec_t vecs[11];

  function automatic logic [15:0] bcd_of(input int n);
    int m;
    m = n % 10000;
    return {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  // Scoreboard
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drivers: always entered and left on a falling edge.
  task automatic step(input logic z, input logic c);
    bus.z   = z;
    bus.clr = c;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_count();
    step(1'b0, 1'b1);
    n_events = 0;
    chk("clr_count", bus.count_bcd, 16'h0000);
  endtask

  task automatic pulse();
    n_events++;
    exp_q.push_back(bcd_of(n_events));
    step(1'b1, 1'b0);
    chk("pulse_count", bus.count_bcd, exp_q.pop_front());
    chk("pulse_det", {15'd0, bus.det_pulse}, 16'd1);
    step(1'b0, 1'b0);
    repeat ($urandom_range(0, 1)) step(1'b0, 1'b0);
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) pulse();
  endtask

  initial begin
    logic [3:0] prev_an;
    logic [3:0] exp_an[4];
    logic [6:0] exp_seg[4];
    int         npulse;
    bit         found;

    n_vec = 0; n_err = 0; n_events = 0;
    vecs[0]  = '{1'b1, 1'b0, 16'h0001, 1'b1};
    vecs[1]  = '{1'b1, 1'b0, 16'h0001, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 16'h0001, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 16'h0001, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 16'h0002, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 16'h0002, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 16'h0000, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 16'h0000, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 16'h0000, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 16'h0001, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 16'h0001, 1'b0};
    exp_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    exp_seg = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};

    reset = 1'b1; bus.z = 1'b0; bus.clr = 1'b0;
    #3;
    chk("rst_count", bus.count_bcd, 16'h0000);
    chk("rst_an", {12'd0, bus.an}, 16'h000E);
    chk("rst_seg", {9'd0, bus.seg}, {9'd0, 7'b1000000});
    chk("rst_pulse", {15'd0, bus.det_pulse}, 16'd0);
    chk("rst_dp", {15'd0, bus.dp}, 16'd1);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    npulse = 0;
    for (int i = 0; i < 50; i++) begin
      step(1'b0, 1'b0);
      if (bus.det_pulse) npulse++;
    end
    chk("idle_count", bus.count_bcd, 16'h0000);
    chk("idle_pulses", 16'(npulse), 16'd0);

    // Vector table
    clear_count();
    for (int i = 0; i < 11; i++) begin
      step(vecs[i].z, vecs[i].clr);
      chk($sformatf("vec%0d_count", i), bus.count_bcd, vecs[i].exp_count);
      chk($sformatf("vec%0d_pulse", i), {15'd0, bus.det_pulse}, {15'd0, vecs[i].exp_pulse});
    end

    // z held high for 5 clocks, three times
    clear_count();
    npulse = 0;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 5; i++) begin
        step(1'b1, 1'b0);
        if (bus.det_pulse) npulse++;
        chk("held_pulse", {15'd0, bus.det_pulse}, (i == 0) ? 16'd1 : 16'd0);
      end
      for (int i = 0; i < 5; i++) begin
        step(1'b0, 1'b0);
        if (bus.det_pulse) npulse++;
      end
    end
    chk("held_count", bus.count_bcd, 16'h0003);
    chk("held_npulse", 16'(npulse), 16'd3);

    // Carry boundaries
    clear_count();
    pulses(9);
    chk("cnt_0009", bus.count_bcd, 16'h0009);
    pulse();
    chk("cnt_0010", bus.count_bcd, 16'h0010);
    pulses(989);
    chk("cnt_0999", bus.count_bcd, 16'h0999);
    pulse();
    chk("cnt_1000", bus.count_bcd, 16'h1000);
    pulses(8999);
    chk("cnt_9999", bus.count_bcd, 16'h9999);
    pulse();
    chk("cnt_wrap", bus.count_bcd, 16'h0000);

    // clr wins over a simultaneous rise
    clear_count();
    pulses(42);
    chk("pre_0042", bus.count_bcd, 16'h0042);
    step(1'b1, 1'b1);
    chk("clr_rise_count", bus.count_bcd, 16'h0000);
    chk("clr_rise_pulse", {15'd0, bus.det_pulse}, 16'd1);
    step(1'b0, 1'b0);
    chk("clr_after", bus.count_bcd, 16'h0000);

    // Scan order with count 1234
    clear_count();
    pulses(1234);
    chk("pre_1234", bus.count_bcd, 16'h1234);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      prev_an = bus.an;
      step(1'b0, 1'b0);
      if (bus.an == 4'b1110 && prev_an != 4'b1110) found = 1'b1;
    end
    chk("scan_align", {15'd0, found}, 16'd1);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("scan%0d_an", k), {12'd0, bus.an}, {12'd0, exp_an[k / 4]});
      chk($sformatf("scan%0d_seg", k), {9'd0, bus.seg}, {9'd0, exp_seg[k / 4]});
      step(1'b0, 1'b0);
    end

    // Asynchronous reset mid-slot with z high
    clear_count();
    pulses(56);
    step(1'b1, 1'b0);
    chk("pre_0057", bus.count_bcd, 16'h0057);
    step(1'b1, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("arst_count", bus.count_bcd, 16'h0000);
    chk("arst_an", {12'd0, bus.an}, 16'h000E);
    chk("arst_seg", {9'd0, bus.seg}, {9'd0, 7'b1000000});
    chk("arst_pulse", {15'd0, bus.det_pulse}, 16'd0);
    @(negedge clk);
    reset = 1'b0;
    step(1'b1, 1'b0);
    chk("post_rst_count", bus.count_bcd, 16'h0001);
    chk("post_rst_pulse", {15'd0, bus.det_pulse}, 16'd1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0);
      chk("post_rst_hold_count", bus.count_bcd, 16'h0001);
      chk("post_rst_hold_pulse", {15'd0, bus.det_pulse}, 16'd0);
    end

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
